// File: rtl/obstacle_scheduler.sv
// Two-slot obstacle sequencer for the pixel animator: spawns obstacles from an
// LFSR, scrolls them once per video frame at a ramping speed and keeps score.
module obstacle_scheduler #(
    parameter logic [9:0] X_SPAWN           = 10'd740,
    parameter logic [3:0] SPEED_INIT        = 4'd2,
    parameter logic [3:0] SPEED_MAX         = 4'd8,
    parameter int         SPEED_STEP_FRAMES = 600,
    parameter logic [7:0] MIN_GAP           = 8'd60,
    parameter int         FLICK_PERIOD      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [1:0]  game_state,
    output logic [1:0]  obs1_type,
    output logic [1:0]  obs2_type,
    output logic [1:0]  obs1_pos,
    output logic [1:0]  obs2_pos,
    output logic [9:0]  obs1_x,
    output logic [9:0]  obs2_x,
    output logic        obs1_active,
    output logic        obs2_active,
    output logic        flick1,
    output logic        flick2,
    output logic [3:0]  speed,
    output logic [15:0] score
);

    localparam int STEP_W = $clog2(SPEED_STEP_FRAMES);
    localparam int FLK_W  = $clog2(FLICK_PERIOD);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SPEED_STEP_FRAMES - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_ZERO = STEP_W'(0);
    localparam logic [FLK_W-1:0]  FLK_LAST  = FLK_W'(FLICK_PERIOD - 1);
    localparam logic [FLK_W-1:0]  FLK_ONE   = FLK_W'(1);
    localparam logic [FLK_W-1:0]  FLK_ZERO  = FLK_W'(0);

    localparam logic [1:0]  MODE_START = 2'b00;
    localparam logic [1:0]  MODE_RUN   = 2'b01;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    logic [1:0]             rst_sync_r;
    logic                   rst_n_s;
    logic [1:0]             mode_r;
    logic [15:0]            lfsr_r;
    logic [1:0][9:0]        x_r, x_s;
    logic [1:0][1:0]        type_r, type_s;
    logic [1:0][1:0]        pos_r, pos_s;
    logic [1:0]             active_r, active_s;
    logic [1:0]             flick_r, flick_s;
    logic [1:0][FLK_W-1:0]  fcnt_r, fcnt_s;
    logic [7:0]             gap_r, gap_s;
    logic [STEP_W-1:0]      step_r, step_s;
    logic [3:0]             speed_r, speed_s;
    logic [15:0]            score_r, score_s;
    logic [1:0]             despawn_s;
    logic [1:0]             spawn_sel_s;
    logic                   spawn_en_s;
    logic [16:0]            score_sum_s;

    // Reset assertion is immediate; release waits two clk edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Next-state for slots, spawn gap, speed ramp and score.
    always_comb begin
        x_s         = x_r;
        type_s      = type_r;
        pos_s       = pos_r;
        active_s    = active_r;
        flick_s     = flick_r;
        fcnt_s      = fcnt_r;
        gap_s       = gap_r;
        step_s      = step_r;
        speed_s     = speed_r;
        score_s     = score_r;
        despawn_s   = 2'd0;
        spawn_en_s  = 1'b0;
        score_sum_s = 17'd0;
        // Eligibility uses occupancy at the start of the frame, lowest slot first.
        spawn_sel_s = {active_r[0] & ~active_r[1], ~active_r[0]};
        case (mode_r)
            MODE_START: begin
                x_s      = {X_SPAWN, X_SPAWN};
                type_s   = {2'b00, 2'b00};
                pos_s    = {2'b00, 2'b00};
                active_s = 2'b00;
                flick_s  = 2'b00;
                fcnt_s   = {FLK_ZERO, FLK_ZERO};
                gap_s    = MIN_GAP;
                step_s   = STEP_ZERO;
                speed_s  = SPEED_INIT;
                score_s  = 16'd0;
            end
            MODE_RUN: begin
                if (frame_tick) begin
                    if (gap_r > 8'd1) begin
                        gap_s = gap_r - 8'd1;
                    end else if (spawn_sel_s != 2'b00) begin
                        spawn_en_s = 1'b1;
                        gap_s      = MIN_GAP + {2'b00, lfsr_r[9:4]};
                    end else begin
                        gap_s = 8'd0;
                    end

                    for (int i = 0; i < 2; i++) begin
                        if (!active_r[i]) begin
                            if (spawn_en_s && spawn_sel_s[i]) begin
                                type_s[i]   = lfsr_r[1:0];
                                pos_s[i]    = (lfsr_r[3:2] == 2'b11) ? 2'b01 : lfsr_r[3:2];
                                x_s[i]      = X_SPAWN;
                                active_s[i] = 1'b1;
                                flick_s[i]  = 1'b0;
                                fcnt_s[i]   = FLK_ZERO;
                            end else begin
                                flick_s[i] = 1'b0;
                                fcnt_s[i]  = FLK_ZERO;
                            end
                        end else if (x_r[i] > {6'd0, speed_r}) begin
                            x_s[i] = x_r[i] - {6'd0, speed_r};
                            if (fcnt_r[i] == FLK_LAST) begin
                                fcnt_s[i]  = FLK_ZERO;
                                flick_s[i] = ~flick_r[i];
                            end else begin
                                fcnt_s[i] = fcnt_r[i] + FLK_ONE;
                            end
                        end else begin
                            active_s[i] = 1'b0;
                            x_s[i]      = X_SPAWN;
                            flick_s[i]  = 1'b0;
                            fcnt_s[i]   = FLK_ZERO;
                            despawn_s   = despawn_s + 2'd1;
                        end
                    end

                    // The new speed takes effect on the following frame.
                    if (step_r == STEP_LAST) begin
                        step_s  = STEP_ZERO;
                        speed_s = (speed_r < SPEED_MAX) ? speed_r + 4'd1 : speed_r;
                    end else begin
                        step_s = step_r + STEP_ONE;
                    end

                    score_sum_s = {1'b0, score_r} + {15'd0, despawn_s};
                    score_s     = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
                end else begin
                    score_sum_s = 17'd0;
                end
            end
            default: begin
                score_sum_s = 17'd0;
            end
        endcase
    end

    // State registers; the LFSR free-runs in every mode.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            mode_r   <= MODE_START;
            lfsr_r   <= LFSR_SEED;
            x_r      <= {X_SPAWN, X_SPAWN};
            type_r   <= {2'b00, 2'b00};
            pos_r    <= {2'b00, 2'b00};
            active_r <= 2'b00;
            flick_r  <= 2'b00;
            fcnt_r   <= {FLK_ZERO, FLK_ZERO};
            gap_r    <= MIN_GAP;
            step_r   <= STEP_ZERO;
            speed_r  <= SPEED_INIT;
            score_r  <= 16'd0;
        end else begin
            mode_r   <= game_state;
            lfsr_r   <= lfsr_next(lfsr_r);
            x_r      <= x_s;
            type_r   <= type_s;
            pos_r    <= pos_s;
            active_r <= active_s;
            flick_r  <= flick_s;
            fcnt_r   <= fcnt_s;
            gap_r    <= gap_s;
            step_r   <= step_s;
            speed_r  <= speed_s;
            score_r  <= score_s;
        end
    end

    assign obs1_type   = type_r[0];
    assign obs2_type   = type_r[1];
    assign obs1_pos    = pos_r[0];
    assign obs2_pos    = pos_r[1];
    assign obs1_x      = x_r[0];
    assign obs2_x      = x_r[1];
    assign obs1_active = active_r[0];
    assign obs2_active = active_r[1];
    assign flick1      = flick_r[0];
    assign flick2      = flick_r[1];
    assign speed       = speed_r;
    assign score       = score_r;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomized bench for obstacle_scheduler against a frame-level reference model
// (ages, spawn deadlines and tick counts rather than hardware counters).
module tb_obstacle_scheduler;

    localparam int X_SPAWN   = 740;
    localparam int MIN_GAP   = 60;
    localparam int STEP      = 600;
    localparam int FLICK     = 8;
    localparam int SPD_INIT  = 2;
    localparam int SPD_MAX   = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic [1:0]  game_state;
    logic [1:0]  obs1_type, obs2_type, obs1_pos, obs2_pos;
    logic [9:0]  obs1_x, obs2_x;
    logic        obs1_active, obs2_active, flick1, flick2;
    logic [3:0]  speed;
    logic [15:0] score;

    obstacle_scheduler dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_state(game_state),
        .obs1_type(obs1_type), .obs2_type(obs2_type),
        .obs1_pos(obs1_pos), .obs2_pos(obs2_pos),
        .obs1_x(obs1_x), .obs2_x(obs2_x),
        .obs1_active(obs1_active), .obs2_active(obs2_active),
        .flick1(flick1), .flick2(flick2),
        .speed(speed), .score(score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [15:0] m_lfsr;
    logic [1:0]  m_mode;
    int          m_rel;
    int          m_x[2], m_type[2], m_pos[2], m_age[2];
    bit          m_act[2];
    int          run_tick, earliest, despawns, frames_done;
    bit          prev_act[2];
    int          last_spawn;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        logic [15:0] taps;
        taps = (16'd1 << 15) | (16'd1 << 13) | (16'd1 << 12) | (16'd1 << 10);
        return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
    endfunction

    function automatic int m_speed();
        int s;
        s = SPD_INIT + run_tick / STEP;
        return (s > SPD_MAX) ? SPD_MAX : s;
    endfunction

    function automatic int m_flick(input int i);
        return m_act[i] ? ((m_age[i] / FLICK) % 2) : 0;
    endfunction

    function automatic int m_score();
        return (despawns > 65535) ? 65535 : despawns;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_x[i] = X_SPAWN; m_type[i] = 0; m_pos[i] = 0; m_act[i] = 1'b0; m_age[i] = 0;
        end
        run_tick = 0; earliest = MIN_GAP; despawns = 0; last_spawn = -1;
    endtask

    task automatic model_frame();
        bit free0, free1;
        int sp, slot;
        free0 = !m_act[0];
        free1 = !m_act[1];
        sp = m_speed();
        run_tick++;
        frames_done++;
        for (int i = 0; i < 2; i++) begin
            if (m_act[i]) begin
                if (m_x[i] > sp) begin
                    m_x[i] -= sp; m_age[i]++;
                end else begin
                    m_act[i] = 1'b0; m_x[i] = X_SPAWN; m_age[i] = 0; despawns++;
                end
            end
        end
        if (run_tick >= earliest && (free0 || free1)) begin
            slot = free0 ? 0 : 1;
            m_type[slot] = int'(m_lfsr[1:0]);
            m_pos[slot]  = (m_lfsr[3:2] == 2'b11) ? 1 : int'(m_lfsr[3:2]);
            m_x[slot]    = X_SPAWN;
            m_act[slot]  = 1'b1;
            m_age[slot]  = 0;
            earliest = run_tick + MIN_GAP + int'(m_lfsr[9:4]);
        end
    endtask

    task automatic model_edge(input logic ft, input logic [1:0] gs, input logic rst);
        if (!rst || m_rel < 2) begin
            m_rel = rst ? m_rel + 1 : 0;
            m_lfsr = SEED; m_mode = 2'b00;
            model_clear();
        end else begin
            case (m_mode)
                2'b00:   model_clear();
                2'b01:   if (ft) model_frame();
                default: ;
            endcase
            m_lfsr = lfsr_adv(m_lfsr);
            m_mode = gs;
        end
    endtask

    task automatic compare_all();
        bit act_now[2];
        check_eq("x1", int'(obs1_x), m_x[0]);
        check_eq("x2", int'(obs2_x), m_x[1]);
        check_eq("active1", int'(obs1_active), int'(m_act[0]));
        check_eq("active2", int'(obs2_active), int'(m_act[1]));
        check_eq("type1", int'(obs1_type), m_type[0]);
        check_eq("type2", int'(obs2_type), m_type[1]);
        check_eq("pos1", int'(obs1_pos), m_pos[0]);
        check_eq("pos2", int'(obs2_pos), m_pos[1]);
        check_eq("flick1", int'(flick1), m_flick(0));
        check_eq("flick2", int'(flick2), m_flick(1));
        check_eq("speed", int'(speed), m_speed());
        check_eq("score", int'(score), m_score());
        act_now[0] = obs1_active;
        act_now[1] = obs2_active;
        for (int i = 0; i < 2; i++) begin
            if (act_now[i] && !prev_act[i]) begin
                if (last_spawn >= 0) check_eq("spawn_gap_ok", int'(run_tick - last_spawn >= MIN_GAP), 1);
                last_spawn = run_tick;
            end
            prev_act[i] = act_now[i];
        end
    endtask

    task automatic cycle(input logic ft, input logic [1:0] gs);
        frame_tick = ft;
        game_state = gs;
        @(posedge clk);
        model_edge(ft, gs, reset);
        #1;
        frame_tick = 1'b0;
        compare_all();
    endtask

    task automatic async_reset_check();
        #2;
        reset = 1'b0;
        #1;
        m_rel = 0; m_lfsr = SEED; m_mode = 2'b00;
        model_clear();
        check_eq("rst_x1", int'(obs1_x), 740);
        check_eq("rst_active1", int'(obs1_active), 0);
        check_eq("rst_speed", int'(speed), 2);
        check_eq("rst_score", int'(score), 0);
        compare_all();
        cycle(1'b0, 2'b00);
        cycle(1'b0, 2'b00);
        reset = 1'b1;
    endtask

    initial begin
        bit         found;
        int         sf, ss, guard, r;
        logic [1:0] gs;

        reset = 1'b1; frame_tick = 1'b0; game_state = 2'b00;
        m_rel = 0; m_lfsr = SEED; m_mode = 2'b00; frames_done = 0;
        prev_act[0] = 1'b0; prev_act[1] = 1'b0;
        model_clear();
        #2;
        reset = 1'b0;
        repeat (3) cycle(1'b0, 2'b00);
        reset = 1'b1;
        repeat ($urandom_range(5, 40)) cycle(1'b0, 2'b00);

        // Directed run: first spawn, first despawn, speed ramp and saturation.
        cycle(1'b0, 2'b01);
        for (int t = 1; t <= 6000; t++) begin
            cycle(1'b1, 2'b01);
            cycle(1'b0, 2'b01);
            if (t == 60) begin
                check_eq("t60_active1", int'(obs1_active), 1);
                check_eq("t60_x1", int'(obs1_x), 740);
            end
            if (t == 61) begin
                check_eq("t61_x1", int'(obs1_x), 738);
                check_eq("t61_pos1_legal", int'(obs1_pos == 2'b11), 0);
            end
            if (t == 430) begin
                check_eq("t430_score", int'(score), 1);
                check_eq("t430_x1", int'(obs1_x), 740);
                check_eq("t430_active1", int'(obs1_active), 0);
            end
            if (t == 600)  check_eq("t600_speed", int'(speed), 3);
            if (t == 3600) check_eq("t3600_speed", int'(speed), 8);
            if (t == 6000) check_eq("t6000_speed", int'(speed), 8);
        end

        // Freeze with obs1 mid-flight at x=500, then return to the start screen.
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            cycle(1'b1, 2'b01);
            cycle(1'b0, 2'b01);
            found = m_act[0] && (m_x[0] == 500);
        end
        check_eq("frz_setup", int'(found), 1);
        sf = m_flick(0);
        ss = m_score();
        cycle(1'b0, 2'b10);
        for (int n = 0; n < 20; n++) begin
            cycle(1'b1, (n < 10) ? 2'b10 : 2'b11);
            cycle(1'b0, (n < 10) ? 2'b10 : 2'b11);
        end
        check_eq("frz_x1", int'(obs1_x), 500);
        check_eq("frz_flick1", int'(flick1), sf);
        check_eq("frz_score", int'(score), ss);
        cycle(1'b0, 2'b00);
        cycle(1'b0, 2'b00);
        check_eq("clr_x1", int'(obs1_x), 740);
        check_eq("clr_active1", int'(obs1_active), 0);
        check_eq("clr_speed", int'(speed), 2);
        check_eq("clr_score", int'(score), 0);
        check_eq("clr_flick1", int'(flick1), 0);

        // Asynchronous reset while obs1 is in flight.
        cycle(1'b0, 2'b01);
        for (int n = 0; n < 100; n++) begin
            cycle(1'b1, 2'b01);
            cycle(1'b0, 2'b01);
        end
        async_reset_check();
        repeat ($urandom_range(3, 30)) cycle(1'b0, 2'b00);

        // Random run with mode changes that may coincide with frame ticks.
        gs = 2'b01;
        frames_done = 0;
        guard = 0;
        while (frames_done < 20000 && guard < 70000) begin
            guard++;
            r = $urandom_range(0, 999);
            if (gs == 2'b01) begin
                if (r < 2) gs = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
                else if (r < 3) gs = 2'b00;
            end else if (r < 50) begin
                gs = 2'b01;
            end
            cycle(1'($urandom_range(0, 2) != 0), gs);
            check_eq("pos1_legal", int'(obs1_pos == 2'b11), 0);
            check_eq("pos2_legal", int'(obs2_pos == 2'b11), 0);
        end
        check_eq("rand_frames", frames_done, 20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
